// File: rtl/trace_mem_sequencer.sv
// Trace playback sequencer: arbitrates the single-port trace SRAM between host loads and playback
// reads, and buffers read data in a small FIFO so the cache model can back-pressure the stream.
module trace_mem_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic              host_ack,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   trace_len,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              trace_valid,
  output logic [DATA_W-1:0] trace_addr,
  input  logic              trace_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   consumed_cnt,
  output logic [1:0]        fsm_state
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   remaining;
  logic              rd_req_q;   // read currently on the SRAM port
  logic              rd_pend_q;  // read whose data is on sram_dout this cycle
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [CW-1:0]     fifo_wp, fifo_rp;
  logic [CW:0]       fifo_count;
  logic [1:0]        inflight;
  logic [CW+1:0]     occupancy;
  logic [ADDR_W:0]   len_clamped;
  logic              active, start_acc, abort, read_grant, push, pop;

  assign active      = (state == S_RUN) || (state == S_DRAIN);
  assign start_acc   = start && !stop && !active;
  assign abort       = stop && active;
  assign len_clamped = (trace_len > MAX_LEN) ? MAX_LEN : trace_len;

  // Credit check counts FIFO entries plus both read pipeline stages, so a push never finds the FIFO full.
  assign inflight   = {1'b0, rd_req_q} + {1'b0, rd_pend_q};
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign read_grant = (state == S_RUN) && !stop && !host_we && (remaining != '0) &&
                      (occupancy < (CW+2)'(FIFO_DEPTH));

  // trace_valid/trace_ready: a transfer happens in any cycle both are high; trace_addr holds while valid && !ready.
  assign trace_valid = (fifo_count != '0);
  assign trace_addr  = fifo_mem[fifo_rp];
  assign push        = rd_pend_q;
  assign pop         = trace_valid && trace_ready;

  assign busy      = active;
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_acc) state_nxt = (len_clamped == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (stop) state_nxt = S_IDLE;
        else if ((remaining == '0) || (read_grant && remaining == (ADDR_W+1)'(1))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (stop) state_nxt = S_IDLE;
        else if ((fifo_count == '0) && (inflight == 2'd0)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (stop) state_nxt = S_IDLE;
        else if (start_acc) state_nxt = (len_clamped == '0) ? S_DONE : S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_csb     <= 1'b1;
      sram_web     <= 1'b1;
      sram_addr    <= '0;
      sram_din     <= '0;
      host_ack     <= 1'b0;
      rd_ptr       <= '0;
      remaining    <= '0;
      rd_req_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      fifo_wp      <= '0;
      fifo_rp      <= '0;
      fifo_count   <= '0;
      consumed_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (host_we) begin
        sram_csb  <= 1'b0;
        sram_web  <= 1'b0;
        sram_addr <= host_addr;
        sram_din  <= host_din;
        host_ack  <= 1'b1;
      end else if (read_grant) begin
        sram_csb  <= 1'b0;
        sram_web  <= 1'b1;
        sram_addr <= rd_ptr;
        host_ack  <= 1'b0;
      end else begin
        sram_csb  <= 1'b1;
        sram_web  <= 1'b1;
        host_ack  <= 1'b0;
      end

      if (start_acc) begin
        rd_ptr    <= base_addr;
        remaining <= len_clamped;
      end else if (abort) begin
        remaining <= '0;
      end else if (read_grant) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end

      rd_req_q  <= read_grant;
      rd_pend_q <= abort ? 1'b0 : rd_req_q;

      if (abort) begin
        fifo_wp    <= '0;
        fifo_rp    <= '0;
        fifo_count <= '0;
      end else begin
        if (push) begin
          fifo_mem[fifo_wp] <= sram_dout;
          fifo_wp           <= fifo_wp + CW'(1);
        end
        if (pop) fifo_rp <= fifo_rp + CW'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + (CW+1)'(1);
          2'b01:   fifo_count <= fifo_count - (CW+1)'(1);
          default: fifo_count <= fifo_count;
        endcase
      end

      if (start_acc) consumed_cnt <= '0;
      else if (pop)  consumed_cnt <= consumed_cnt + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_trace_mem_sequencer.sv
// Bench for trace_mem_sequencer: behavioural SRAM, directed playback runs, and a negedge monitor
// checking playback data and SRAM read addresses against expected queues.
module tb_trace_mem_sequencer;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic          host_ack;
  logic          start, stop;
  logic [AW-1:0] base_addr;
  logic [AW:0]   trace_len;
  logic          sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;
  logic          trace_valid;
  logic [DW-1:0] trace_addr;
  logic          trace_ready;
  logic          busy, done;
  logic [AW:0]   consumed_cnt;
  logic [1:0]    fsm_state;

  trace_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_we(host_we), .host_addr(host_addr), .host_din(host_din), .host_ack(host_ack),
    .start(start), .stop(stop), .base_addr(base_addr), .trace_len(trace_len),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout),
    .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_ready(trace_ready),
    .busy(busy), .done(done), .consumed_cnt(consumed_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // behavioural SRAM: one-cycle read latency
  logic [DW-1:0] sram_mem  [1<<AW];
  logic [DW-1:0] model_mem [1<<AW];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) sram_mem[sram_addr] <= sram_din;
      else           sram_dout <= sram_mem[sram_addr];
    end
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] rd_q[$];
  int ack_cnt = 0, rd_seen = 0, xfer_seen = 0, max_occ = 0, sram_acc = 0;
  int first_valid_cyc = 0, first_xfer_cyc = 0, last_xfer_cyc = 0, start_cyc = 0;
  bit seen_valid = 0, seen_xfer = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (host_ack) ack_cnt++;
      if (!sram_csb) begin
        sram_acc++;
        if (sram_web) begin
          rd_seen++;
          if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_extra actual=%0d expected=none", sram_addr);
          end else begin
            chk("rd_addr", 64'(sram_addr), 64'(rd_q.pop_front()));
          end
        end
      end
      if (rd_seen - xfer_seen > max_occ) max_occ = rd_seen - xfer_seen;
      if (prev_stall && trace_valid) chk("stall_hold", 64'(trace_addr), 64'(prev_addr));
      if (trace_valid && !seen_valid) begin
        seen_valid      = 1;
        first_valid_cyc = cyc;
      end
      if (trace_valid && trace_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL trace_extra actual=%0h expected=none", trace_addr);
        end else begin
          chk("trace_addr", 64'(trace_addr), 64'(exp_q.pop_front()));
        end
        xfer_seen++;
        if (!seen_xfer) begin
          seen_xfer      = 1;
          first_xfer_cyc = cyc;
        end
        last_xfer_cyc = cyc;
      end
      prev_stall = trace_valid && !trace_ready;
      prev_addr  = trace_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_load(input logic [AW-1:0] base, input int n, input logic [DW-1:0] dbase);
    for (int i = 0; i < n; i++) begin
      tick();
      host_we   = 1'b1;
      host_addr = base + AW'(i);
      host_din  = dbase + DW'(i);
      model_mem[host_addr] = host_din;
    end
    tick();
    host_we = 1'b0;
  endtask

  task automatic play(input logic [AW-1:0] base, input logic [AW:0] len);
    int n;
    logic [AW-1:0] a;
    n = (len > 11'd1024) ? 1024 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      exp_q.push_back(model_mem[a]);
      rd_q.push_back(a);
    end
    rd_seen = 0; xfer_seen = 0; max_occ = 0; seen_valid = 0; seen_xfer = 0;
    tick();
    start = 1'b1; base_addr = base; trace_len = len;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    for (int k = 0; k < budget && !done; k++) begin
      if (rand_ready) trace_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("done_reached", 64'(done), 64'(1));
  endtask

  task automatic finish_run(input int n, input int budget, input bit rand_ready);
    wait_done(budget, rand_ready);
    trace_ready = 1'b1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
    chk("consumed_cnt", 64'(consumed_cnt), 64'(n));
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("occupancy_le_depth", 64'(max_occ <= FD), 64'(1));
  endtask

  task automatic check_reset_vals();
    chk("rst_sram_csb", 64'(sram_csb), 64'(1));
    chk("rst_sram_web", 64'(sram_web), 64'(1));
    chk("rst_sram_addr", 64'(sram_addr), 64'(0));
    chk("rst_sram_din", 64'(sram_din), 64'(0));
    chk("rst_host_ack", 64'(host_ack), 64'(0));
    chk("rst_trace_valid", 64'(trace_valid), 64'(0));
    chk("rst_trace_addr", 64'(trace_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_consumed", 64'(consumed_cnt), 64'(0));
    chk("rst_state", 64'(fsm_state), 64'(0));
  endtask

  int snap;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      sram_mem[i]  = 32'hA000_0000 + 32'(i * 7);
      model_mem[i] = 32'hA000_0000 + 32'(i * 7);
    end
    reset_n = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
    start = 1'b0; stop = 1'b0; base_addr = '0; trace_len = '0; trace_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();

    // load 0..7 and play them back at full rate
    ack_cnt = 0;
    host_load(10'd0, 8, 32'h100);
    tick();
    chk("load_acks", 64'(ack_cnt), 64'(8));
    trace_ready = 1'b1;
    play(10'd0, 11'd8);
    finish_run(8, 300, 0);
    chk("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'(3));
    chk("back_to_back", 64'(last_xfer_cyc - first_xfer_cyc), 64'(7));

    // address wrap 1020..1023, 0..3
    play(10'd1020, 11'd8);
    finish_run(8, 300, 0);

    // random back-pressure
    play(10'd600, 11'd64);
    finish_run(64, 2000, 1);

    // host writes during RUN steal the port for five cycles
    play(10'd16, 11'd32);
    tick(); tick();
    ack_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      host_we   = 1'b1;
      host_addr = 10'd900 + 10'(i);
      host_din  = 32'hBEEF_0000 + 32'(i);
      model_mem[host_addr] = host_din;
      tick();
    end
    host_we = 1'b0;
    finish_run(32, 300, 0);
    chk("run_host_acks", 64'(ack_cnt), 64'(5));
    play(10'd900, 11'd5);
    finish_run(5, 300, 0);

    // stop after ten transfers with the consumer stalled
    trace_ready = 1'b0;
    play(10'd200, 11'd64);
    repeat (10) tick();
    trace_ready = 1'b1;
    repeat (10) tick();
    trace_ready = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", 64'(trace_valid), 64'(0));
    chk("stop_state", 64'(fsm_state), 64'(0));
    chk("stop_busy", 64'(busy), 64'(0));
    chk("stop_consumed", 64'(consumed_cnt), 64'(10));
    chk("stop_xfers", 64'(xfer_seen), 64'(10));
    exp_q.delete();
    rd_q.delete();
    tick();
    trace_ready = 1'b1;
    play(10'd40, 11'd6);
    finish_run(6, 300, 0);

    // zero length, then start+stop together from DONE
    snap = sram_acc;
    play(10'd123, 11'd0);
    chk("len0_done", 64'(done), 64'(1));
    chk("len0_state", 64'(fsm_state), 64'(3));
    tick(); tick();
    chk("len0_no_sram", 64'(sram_acc), 64'(snap));
    chk("len0_consumed", 64'(consumed_cnt), 64'(0));
    tick();
    start = 1'b1; stop = 1'b1; base_addr = 10'd5; trace_len = 11'd4;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_state", 64'(fsm_state), 64'(0));
    chk("startstop_done", 64'(done), 64'(0));
    repeat (5) tick();
    chk("startstop_busy", 64'(busy), 64'(0));
    chk("startstop_no_sram", 64'(sram_acc), 64'(snap));

    // oversized length clamps to the full SRAM
    play(10'd0, 11'd1500);
    finish_run(1024, 1400, 0);

    // asynchronous reset mid-run
    trace_ready = 1'b0;
    play(10'd50, 11'd64);
    repeat (6) tick();
    chk("pre_reset_busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    rd_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    trace_ready = 1'b1;
    play(10'd8, 11'd4);
    finish_run(4, 300, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
